// File: rtl/router_pkg.sv
// Shared definitions for the deflection router stages (ejector, injector).
// Holds the flit field layout, the link channel indices, the direction codes
// and the rotating-priority pick helper.
package router_pkg;

  // Flit field positions: [9] golden, [8:6] direction, [5:3] row, [2:0] col.
  localparam int GOLD_BIT = 9;
  localparam int DIR_HI   = 8;
  localparam int DIR_LO   = 6;
  localparam int ROW_HI   = 5;
  localparam int ROW_LO   = 3;
  localparam int COL_HI   = 2;
  localparam int COL_LO   = 0;

  // Link channel indices; also the bit order of the per-channel valids.
  localparam int EAST  = 0;
  localparam int WEST  = 1;
  localparam int NORTH = 2;
  localparam int SOUTH = 3;

  typedef enum logic [2:0] {
    DIR_EAST  = 3'b000,
    DIR_WEST  = 3'b001,
    DIR_NORTH = 3'b010,
    DIR_SOUTH = 3'b011,
    DIR_LOCAL = 3'b100
  } dir_e;

  // First set bit of req scanning upward from index start, wrapping mod 4.
  // Iterating from the largest offset down lets the smallest offset win.
  // Returns start when req is empty; callers qualify with |req.
  function automatic logic [1:0] rr_pick(input logic [1:0] start,
                                         input logic [3:0] req);
    logic [1:0] idx;
    rr_pick = start;
    for (int unsigned j = 4; j > 0; j--) begin
      idx = start + 2'(j - 1);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/ejector_if.sv
// Link/core bundle of the ejector.
//   eastad/westad/northad/southad, in_v : incoming link flits and valids
//   ead/wad/nad/sad, out_v              : flits forwarded to the injector
//   localad, local_v, local_rdy         : eject FIFO head toward the core
//   eject_cnt                           : eject FIFO occupancy
// master = upstream links + core side, slave = ejector side.
interface ejector_if #(
  parameter int FLIT_W = 10,
  parameter int CNT_W  = 3
);
  logic [FLIT_W-1:0] eastad;
  logic [FLIT_W-1:0] westad;
  logic [FLIT_W-1:0] northad;
  logic [FLIT_W-1:0] southad;
  logic [3:0]        in_v;
  logic [FLIT_W-1:0] ead;
  logic [FLIT_W-1:0] wad;
  logic [FLIT_W-1:0] nad;
  logic [FLIT_W-1:0] sad;
  logic [3:0]        out_v;
  logic [FLIT_W-1:0] localad;
  logic              local_v;
  logic              local_rdy;
  logic [CNT_W-1:0]  eject_cnt;

  modport master (
    output eastad, westad, northad, southad, in_v, local_rdy,
    input  ead, wad, nad, sad, out_v, localad, local_v, eject_cnt
  );

  modport slave (
    input  eastad, westad, northad, southad, in_v, local_rdy,
    output ead, wad, nad, sad, out_v, localad, local_v, eject_cnt
  );
endinterface

// File: rtl/ejector_fifo.sv
// eject_fifo: DEPTH x W synchronous FIFO holding flits ejected at this node.
//   clk, rst  : clock, synchronous active-high reset (contents discarded)
//   push_i    : write din_i (ignored when full)
//   pop_i     : consume the head (ignored when empty)
//   dout_o    : head entry, zero when empty
//   empty_o   : no entries
//   full_o    : DEPTH entries
//   count_o   : occupancy 0..DEPTH
module eject_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/ejector.sv
// ejector: ejection stage of the deflection router, upstream of the injector.
// Each cycle at most one valid flit addressed to {ROW_ID,COL_ID} is removed
// from the four links and queued in the eject FIFO; its slot goes out empty
// so the injector can reuse it. All other flits are registered through.
//   clk, rst : clock, synchronous active-high reset
//   link     : ejector_if.slave (link inputs, injector slots, core FIFO port)
module ejector
  import router_pkg::*;
#(
  parameter int         FLIT_W = 10,
  parameter logic [2:0] ROW_ID = 3'd4,
  parameter logic [2:0] COL_ID = 3'd4,
  parameter int         DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  ejector_if.slave   link
);
  localparam int NCH = 4;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] in_flit [NCH];
  logic [NCH-1:0]    cand, gold;
  logic [1:0]        sel_k;
  logic              eject;

  logic [FLIT_W-1:0] out_flit_q [NCH];
  logic [FLIT_W-1:0] out_flit_d [NCH];
  logic [NCH-1:0]    out_v_q, out_v_d;
  logic [1:0]        rr_q, rr_d;

  logic              fifo_empty, fifo_full;
  logic [FLIT_W-1:0] fifo_head;
  logic [CW-1:0]     fifo_cnt;

  assign in_flit[EAST]  = link.eastad;
  assign in_flit[WEST]  = link.westad;
  assign in_flit[NORTH] = link.northad;
  assign in_flit[SOUTH] = link.southad;

  always_comb begin
    cand = '0;
    gold = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand[i] = link.in_v[i] &&
                (in_flit[i][ROW_HI:COL_LO] == {ROW_ID, COL_ID});
      gold[i] = cand[i] && in_flit[i][GOLD_BIT];
    end
  end

  // Golden flits bypass the round-robin and go lowest index first.
  assign sel_k = (|gold) ? rr_pick(2'd0, gold) : rr_pick(rr_q, cand);
  // Space is judged on the registered count; a same-cycle pop does not help.
  assign eject = (|cand) && !fifo_full;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      out_flit_d[i] = in_flit[i];
      out_v_d[i]    = link.in_v[i];
    end
    rr_d = rr_q;
    if (eject) begin
      out_flit_d[sel_k] = '0;
      out_v_d[sel_k]    = 1'b0;
      rr_d              = sel_k + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) out_flit_q[i] <= '0;
      out_v_q <= '0;
      rr_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) out_flit_q[i] <= out_flit_d[i];
      out_v_q <= out_v_d;
      rr_q    <= rr_d;
    end
  end

  eject_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (eject),
    .din_i   (in_flit[sel_k]),
    .pop_i   (link.local_rdy),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign link.ead       = out_flit_q[EAST];
  assign link.wad       = out_flit_q[WEST];
  assign link.nad       = out_flit_q[NORTH];
  assign link.sad       = out_flit_q[SOUTH];
  assign link.out_v     = out_v_q;
  assign link.localad   = fifo_head;
  assign link.local_v   = !fifo_empty;
  assign link.eject_cnt = fifo_cnt;
endmodule

// File: tb/tb_ejector.sv
module tb_ejector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ejector_if #(.FLIT_W(10), .CNT_W(3)) bus ();

  ejector #(
    .FLIT_W (10),
    .ROW_ID (3'd4),
    .COL_ID (3'd4),
    .DEPTH  (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .link (bus)
  );

  typedef struct {
    int              due;
    logic [3:0]      v;
    logic [3:0]      mask;
    logic [3:0][9:0] f;
    int              cnt;
    int              lv;
  } exp_t;

  exp_t       exp_link [$];
  logic [9:0] exp_local [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Drive one link vector; k is the hand-computed ejected channel (-1: none).
  task automatic vec(input logic [9:0] e, input logic [9:0] w, input logic [9:0] n,
                     input logic [9:0] s, input logic [3:0] v, input logic rdy,
                     input int k, input int xcnt, input int xlv);
    exp_t x;
    @(posedge clk); #2;
    rst = 1'b0;
    bus.eastad = e; bus.westad = w; bus.northad = n; bus.southad = s;
    bus.in_v = v; bus.local_rdy = rdy;
    x.due = cyc + 1;
    x.f = {s, n, w, e};
    x.v = v;
    x.mask = v;
    if (k >= 0) begin
      exp_local.push_back(x.f[k]);
      x.v[k] = 1'b0;
      x.f[k] = '0;
      x.mask[k] = 1'b1;
    end
    x.cnt = xcnt;
    x.lv = xlv;
    exp_link.push_back(x);
  endtask

  // Reset cycle with a local candidate on east that must not be ejected.
  task automatic do_reset();
    exp_t x;
    @(posedge clk); #2;
    rst = 1'b1;
    bus.eastad = 10'h024; bus.westad = '0; bus.northad = '0; bus.southad = '0;
    bus.in_v = 4'b0001; bus.local_rdy = 1'b0;
    exp_local.delete();
    x.due = cyc + 1;
    x.v = '0;
    x.mask = 4'hF;
    x.f = '0;
    x.cnt = 0;
    x.lv = 0;
    exp_link.push_back(x);
  endtask

  // Monitor: link slots checked against the entry due this cycle; FIFO head
  // checked against the ejection-order queue whenever a pop is presented.
  exp_t            mx;
  logic [3:0][9:0] act_f;
  always @(negedge clk) begin
    while (exp_link.size() > 0 && exp_link[0].due == cyc) begin
      mx = exp_link.pop_front();
      act_f = {bus.sad, bus.nad, bus.wad, bus.ead};
      chk("out_v", 32'(bus.out_v), 32'(mx.v));
      for (int i = 0; i < 4; i++)
        if (mx.mask[i]) chk($sformatf("slot%0d", i), 32'(act_f[i]), 32'(mx.f[i]));
      chk("eject_cnt", 32'(bus.eject_cnt), 32'(mx.cnt));
      chk("local_v", 32'(bus.local_v), 32'(mx.lv));
    end
    if (!rst && bus.local_v && bus.local_rdy) begin
      if (exp_local.size() == 0) begin
        chk("local_extra", 32'(bus.localad), 32'h3FF);
      end else begin
        chk("localad", 32'(bus.localad), 32'(exp_local.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.eastad = '0; bus.westad = '0; bus.northad = '0; bus.southad = '0;
    bus.in_v = '0; bus.local_rdy = 1'b0;
    do_reset();
    // single candidate, pass-through, golden priority, drain
    vec(10'h024, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 1, 1);
    vec(10'h000, 10'h000, 10'h01B, 10'h000, 4'b0100, 1'b0, -1, 1, 1);
    vec(10'h024, 10'h000, 10'h000, 10'h224, 4'b1001, 1'b0,  3, 2, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 1, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 0, 0);
    // round-robin with four local candidates each cycle, rr starts at 0
    vec(10'h024, 10'h0A4, 10'h124, 10'h064, 4'b1111, 1'b1,  0, 1, 1);
    vec(10'h024, 10'h0A4, 10'h124, 10'h064, 4'b1111, 1'b1,  1, 1, 1);
    vec(10'h024, 10'h0A4, 10'h124, 10'h064, 4'b1111, 1'b1,  2, 1, 1);
    vec(10'h024, 10'h0A4, 10'h124, 10'h064, 4'b1111, 1'b1,  3, 1, 1);
    vec(10'h024, 10'h0A4, 10'h124, 10'h064, 4'b1111, 1'b1,  0, 1, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 0, 0);
    // two golden candidates with rr=1: lowest golden index still wins
    vec(10'h224, 10'h0A4, 10'h324, 10'h000, 4'b0111, 1'b1,  0, 1, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 0, 0);
    // fill the FIFO; the fifth local flit is deflected
    vec(10'h024, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 1, 1);
    vec(10'h0A4, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 2, 1);
    vec(10'h124, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 3, 1);
    vec(10'h064, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 4, 1);
    vec(10'h1E4, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0, -1, 4, 1);
    // pop at full does not free space for a same-cycle push
    vec(10'h000, 10'h0A4, 10'h000, 10'h000, 4'b0010, 1'b1, -1, 3, 1);
    vec(10'h000, 10'h0A4, 10'h000, 10'h000, 4'b0010, 1'b1,  1, 3, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 2, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 1, 1);
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 0, 0);
    // reset with three flits queued, then a pop attempt on the empty FIFO
    vec(10'h024, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 1, 1);
    vec(10'h0A4, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 2, 1);
    vec(10'h124, 10'h000, 10'h000, 10'h000, 4'b0001, 1'b0,  0, 3, 1);
    do_reset();
    vec(10'h000, 10'h000, 10'h000, 10'h000, 4'b0000, 1'b1, -1, 0, 0);
    vec(10'h000, 10'h01B, 10'h000, 10'h000, 4'b0010, 1'b1, -1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("link_q_left", 32'(exp_link.size()), 32'd0);
    chk("local_q_left", 32'(exp_local.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
